wb_dbg_master: RTL
==================

// Module: wb_dbg_master
// PURPOSE
//  Byte-stream-driven Wishbone (pipelined, B4) bus master for host debug access to the SoC bus.
//  Parses read/write commands from a byte source (e.g. UART RX FIFO) and performs single 32-bit transfers.
//  Returns status/data bytes on a byte sink (e.g. UART TX FIFO).
//  Sits as a second master on the wbxbar, next to the CPU.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  cycles with cyc_o high and no ack/err before abort (only with WB_DBG_TIMEOUT_EN)
// PORTS
//  wb_clk_i     in   1   bus clock; all logic on its rising edge
//  wb_rst_i     in   1   synchronous, active-high reset
//  rx_data_i    in   8   command byte
//  rx_valid_i   in   1   rx_data_i valid
//  rx_ready_o   out  1   byte accepted when rx_valid_i & rx_ready_o
//  tx_data_o    out  8   response byte
//  tx_valid_o   out  1   tx_data_o valid; held with stable data until tx_ready_i
//  tx_ready_i   in   1   sink accepts byte
//  wbm_adr_o    out  32  byte address
//  wbm_dat_o    out  32  write data
//  wbm_dat_i    in   32  read data
//  wbm_we_o     out  1   write enable
//  wbm_sel_o    out  4   byte select; always 4'hF during transfer
//  wbm_cyc_o    out  1   bus cycle
//  wbm_stb_o    out  1   strobe
//  wbm_ack_i    in   1   slave ack
//  wbm_err_i    in   1   slave error
//  wbm_stall_i  in   1   slave stall
//  busy_o       out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; byte counter 0; addr/data regs 0.
//  Frame (LSB first): WR = 8'hA5, A0..A3, D0..D3; RD = 8'h5A, A0..A3.
//  Response: WR -> 1 status byte; RD -> status, then D0..D3 (LSB first). Status: 8'h00 ok, 8'hEE err/timeout, 8'hFE bad opcode.
//  On RD error/timeout the 4 data bytes are still sent as 8'h00.
//  States:
//   IDLE     rx_ready_o=1; A5 -> ADDR(we=1); 5A -> ADDR(we=0); other -> RESP with FE, no bus access
//   ADDR     rx_ready_o=1; shift in 4 bytes; then WR -> DATA, RD -> BUS_REQ
//   DATA     rx_ready_o=1; shift in 4 bytes -> BUS_REQ
//   BUS_REQ  cyc=stb=1; leave when !stall_i -> BUS_WAIT
//            if ack_i/err_i already seen in this cycle: capture it, go to RESP
//   BUS_WAIT cyc=1, stb=0; ack_i -> capture dat_i (RD), status 00; err_i -> status EE (err wins if both)
//            either ends the cycle (cyc=0 next) -> RESP
//   RESP     tx_valid_o=1; advance byte on tx_ready_i; after last byte -> IDLE
//  rx_ready_o=0 in BUS_REQ/BUS_WAIT/RESP; rx bytes held off, never dropped.
//  Bus fields registered: adr/dat/we stable from stb rise to ack.
//  Exactly one stb per frame.
//  Min latency, last rx byte accepted -> stb high: 1 cycle.
//  ack -> tx_valid: 1 cycle.
//  Reset mid-transfer: cyc/stb drop next cycle; partial frame discarded.
//  ack/err while cyc=0: ignored.
// CONFIGURATION
//  WB_DBG_TIMEOUT_EN defined:
//   - cycle counter starts at stb rise, cleared on leaving BUS_WAIT
//   - at TIMEOUT_CYCLES in BUS_REQ/BUS_WAIT: drop cyc/stb, status EE -> RESP
//  Not defined: no counter; the master waits indefinitely for ack/err.
// STRUCTURE
//  Package wb_dbg_pkg:
//   - CMD_WR=8'hA5, CMD_RD=8'h5A
//   - ST_OK=8'h00, ST_ERR=8'hEE, ST_BADCMD=8'hFE
//   - typedef enum logic [2:0] wb_dbg_state_t {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP}
//  Single module, no sub-modules; response serializer is a 5-byte shift register in this module.
// TESTING
//  1 Write, slave ack after 2 cycles
//    rx A5,10,00,00,02,EF,BE,AD,DE
//    -> one stb: adr 0200_0010, dat DEAD_BEEF, we=1, sel F; tx 00
//  2 Read, dat_i=1234_5678 with stall held 3 cycles
//    rx 5A,00,00,00,01
//    -> stb held 3 cycles plus 1; tx 00,78,56,34,12
//  3 Read answered with err_i
//    -> tx EE,00,00,00,00; cyc low 1 cycle after err
//  4 Bad opcode: rx 33 -> tx FE; no cyc; next A5 frame works
//  5 tx_ready_i low 10 cycles mid-response -> tx_data_o stable, no byte lost; rx_ready_o=0 meanwhile
//  6 WB_DBG_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave silent -> cyc drops after 16 cycles, tx EE;
//    without macro cyc stays high; reset clears it

Source files
------------

// File: rtl/wb_dbg_pkg.sv
// Shared constants and state type for the byte-stream Wishbone debug master.
// Holds the command opcodes, the response status codes and the FSM state enum.
// Ports: none (package).
package wb_dbg_pkg;

  localparam logic [7:0] CMD_WR    = 8'hA5;
  localparam logic [7:0] CMD_RD    = 8'h5A;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_ERR    = 8'hEE;
  localparam logic [7:0] ST_BADCMD = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_REQ,
    BUS_WAIT,
    RESP
  } wb_dbg_state_t;

endpackage

// File: rtl/wb_dbg_master_if.sv
// Bundle of the byte-source, byte-sink and Wishbone master signals of wb_dbg_master.
// Signal names keep the master's point of view (_i = into the master, _o = out of it).
// Modports: master (the debug master itself), slave (the environment: FIFOs + bus).
interface wb_dbg_master_if;

  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_stall_i;
  logic        busy_o;

  modport master (
    input  rx_data_i, rx_valid_i, tx_ready_i,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i,
    output rx_ready_o, tx_data_o, tx_valid_o,
    output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    output busy_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, tx_ready_i,
    output wbm_dat_i, wbm_ack_i, wbm_err_i, wbm_stall_i,
    input  rx_ready_o, tx_data_o, tx_valid_o,
    input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o, wbm_cyc_o, wbm_stb_o,
    input  busy_o
  );

endinterface

// File: rtl/wb_dbg_master.sv
// Purpose : host debug master; parses A5 (write) / 5A (read) byte frames, runs one
//           32-bit pipelined Wishbone transfer and streams status (+ read data) back.
// Latency : last rx byte accepted -> stb high 1 cycle; ack/err -> tx_valid 1 cycle.
// Backpr. : rx held off (rx_ready_o=0) while on the bus or responding; tx byte held
//           stable until tx_ready_i.
// Ports   : wb_clk_i, wb_rst_i (sync, active high); bus = wb_dbg_master_if.master.
// Option  : WB_DBG_TIMEOUT_EN adds the TIMEOUT_CYCLES parameter and aborts a transfer
//           that sees no ack/err within TIMEOUT_CYCLES cycles of stb rising.
module wb_dbg_master
  import wb_dbg_pkg::*;
`ifdef WB_DBG_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1024)
`endif
  (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wb_dbg_master_if.master bus
);

  wb_dbg_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic [39:0]   sr_q, sr_d;     // response bytes, LSB byte goes out first
  logic [2:0]    left_q, left_d; // response bytes still to send

  logic          rx_fire, tx_fire, in_bus, tmo_hit;
  logic [7:0]    done_status;
  logic [31:0]   done_data;

  assign in_bus  = (state_q == BUS_REQ) || (state_q == BUS_WAIT);
  assign rx_fire = bus.rx_valid_i && bus.rx_ready_o;
  assign tx_fire = bus.tx_valid_o && bus.tx_ready_i;

`ifdef WB_DBG_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts cycles spent on the bus; zero whenever the FSM is elsewhere, so it
  // restarts from zero on the cycle stb rises.
  assign tmo_hit = in_bus && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d = '0;
    if (in_bus && !tmo_hit) tmo_d = tmo_q + TmoW'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Completion status: err wins over ack; no ack at all means timeout.
  always_comb begin
    done_status = (bus.wbm_ack_i && !bus.wbm_err_i) ? ST_OK : ST_ERR;
    done_data   = (bus.wbm_ack_i && !bus.wbm_err_i && !we_q) ? bus.wbm_dat_i : 32'h0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    sr_d    = sr_q;
    left_d  = left_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        cnt_d = 2'd0;
        if (bus.rx_data_i == CMD_WR) begin
          we_d    = 1'b1;
          state_d = ADDR;
        end else if (bus.rx_data_i == CMD_RD) begin
          we_d    = 1'b0;
          state_d = ADDR;
        end else begin
          sr_d    = {32'h0, ST_BADCMD};
          left_d  = 3'd1;
          state_d = RESP;
        end
      end
      ADDR: if (rx_fire) begin
        adr_d = {bus.rx_data_i, adr_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (we_q) begin
            state_d = DATA;
          end else begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = BUS_REQ;
          end
        end
      end
      DATA: if (rx_fire) begin
        dat_d = {bus.rx_data_i, dat_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS_REQ;
        end
      end
      BUS_REQ, BUS_WAIT: begin
        if (bus.wbm_ack_i || bus.wbm_err_i || tmo_hit) begin
          // A response in the stb cycle itself is taken directly.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          sr_d    = {done_data, done_status};
          left_d  = we_q ? 3'd1 : 3'd5;
          state_d = RESP;
        end else if ((state_q == BUS_REQ) && !bus.wbm_stall_i) begin
          stb_d   = 1'b0;
          state_d = BUS_WAIT;
        end
      end
      RESP: if (tx_fire) begin
        sr_d   = {8'h00, sr_q[39:8]};
        left_d = left_q - 3'd1;
        if (left_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      sr_q    <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      sr_q    <= sr_d;
      left_q  <= left_d;
    end
  end

  // rx_ready is gated by reset so every output reads 0 while reset is held.
  assign bus.rx_ready_o = !wb_rst_i &&
                          ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
  assign bus.tx_valid_o = (state_q == RESP);
  assign bus.tx_data_o  = sr_q[7:0];
  assign bus.wbm_adr_o  = adr_q;
  assign bus.wbm_dat_o  = dat_q;
  assign bus.wbm_we_o   = we_q;
  assign bus.wbm_sel_o  = {4{cyc_q}};
  assign bus.wbm_cyc_o  = cyc_q;
  assign bus.wbm_stb_o  = stb_q;
  assign bus.busy_o     = (state_q != IDLE);

endmodule
